dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 64-word single-port data memory.
- Requester 0 is the core load/store unit; requester 1 is the debug/program-loader port.
- Grants one access per cycle with round-robin fairness and drives the memory's address, write-data and write-enable.
- Returns a registered, per-port response that is held until the requester accepts it.

Parameters:
- ADDR_LEN, 32, requester/memory word-address width (the memory decodes addr[5:0]).
- DATA_LEN, 32, data width.
- MEM_WORDS_LOG2, 6, log2 of memory depth; used by the optional bounds check.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pN_req  in  1  request valid, N=0,1; held with its fields until granted.
- pN_we  in  1  1 = store, 0 = load.
- pN_addr  in  ADDR_LEN  word address.
- pN_wdata  in  DATA_LEN  store data.
- pN_gnt  out  1  combinational; request accepted this cycle.
- pN_rvalid  out  1  response valid.
- pN_rdata  out  DATA_LEN  load data; 0 for stores.
- pN_rready  in  1  requester consumes the response.
- dmem_addr  out  ADDR_LEN  to memory address.
- dmem_wdata  out  DATA_LEN  to memory write data.
- dmem_we  out  1  to memory write enable.
- dmem_rdata  in  DATA_LEN  memory combinational read data.

Behaviour:
- Reset: all pN_gnt, pN_rvalid and dmem_we are 0; pN_rdata is 0; the round-robin pointer favours port 0. Reset is asynchronous and is honoured mid-transaction: any pending response is dropped and an in-flight write is suppressed, because dmem_we is gated off by reset.
- Eligibility: port N is eligible when pN_req=1 and (pN_rvalid=0 or pN_rready=1), i.e. it has one outstanding response slot and the slot may free in the same cycle as the new request.
- Arbitration:
  - Only one port eligible: that port is granted.
  - Both eligible: the port not granted most recently wins.
  - The pointer updates only on a grant.
- Memory drive:
  - The granted port's addr and wdata are muxed to the memory; dmem_we = granted port's pN_we.
  - With no grant, dmem_addr=0, dmem_wdata=0, dmem_we=0.
- Latency:
  - The write commits at the rising edge ending the grant cycle.
  - Load data is sampled from dmem_rdata in the grant cycle.
  - pN_rvalid rises on the next edge: response latency is 1 cycle.
- Response: pN_rvalid stays high and pN_rdata stays stable until a cycle where pN_rready=1. If rready and a new grant to the same port occur together, rvalid stays 1 with the new data.
- Per-port FSM:
  - RSP_IDLE -> RSP_VALID on grant.
  - RSP_VALID -> RSP_IDLE on rready without a new grant.
  - RSP_VALID -> RSP_VALID on rready with a new grant.
- Ordering: same-cycle requests are serialized in grant order. A load granted the cycle after a store to the same address returns the new data.
- pN_rready while pN_rvalid=0 is ignored.

Optional Feature:
- Macro DMEM_ARB_BOUNDS_CHECK_EN.
- When defined:
  - Adds outputs p0_rerr and p1_rerr, which are registered alongside rvalid.
  - A granted access with any of pN_addr[ADDR_LEN-1:MEM_WORDS_LOG2] nonzero forces dmem_we=0, returns rdata=0, and sets pN_rerr=1 for that response.
- When undefined:
  - No rerr ports exist.
  - High address bits are passed through to dmem_addr unchanged; the memory aliases them.

Decomposition:
- Shared package or constants header holds:
  - ADDR_LEN and DATA_LEN, reused from the existing constants header.
  - Encodings for the response FSM: RSP_IDLE=0, RSP_VALID=1.
  - Port index localparams: PORT_LSU=0, PORT_DBG=1.
- One sub-module: dmem_arb_rsp, the per-port response holding register plus FSM, instantiated twice.
- The round-robin grant logic stays in the top module.

Test Plan:
- Reset then idle: reset_n low for 3 cycles -> all gnt/rvalid/dmem_we=0, rdata=0; release, no requests -> outputs stay 0.
- Single store then load on port 0:
  - Store addr 5, data 0xDEADBEEF -> p0_gnt=1 and dmem_we=1 that cycle; p0_rvalid=1 next cycle.
  - rready, then load addr 5 -> p0_rdata=0xDEADBEEF one cycle after grant.
- Contention: both ports request loads continuously with rready=1 -> grants alternate p0,p1,p0,p1.
  - First grant goes to p0 after reset.
  - No port is granted twice in a row.
- Backpressure: p1 response pending with p1_rready=0 for 4 cycles while p1_req=1 -> p1_gnt=0 and p1_rdata held; p0 is granted every cycle; raising rready gives p1_gnt the same cycle.
- Reset mid-operation: assert reset_n low during a p0 store grant to addr 9 -> dmem_we drops immediately; p0_rvalid=0; memory word 9 keeps its old value.
- With DMEM_ARB_BOUNDS_CHECK_EN: p1 store to addr 0x40 -> dmem_we=0; next cycle p1_rvalid=1, p1_rerr=1, rdata=0; word 0 is unchanged.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and response-FSM encoding for the data-memory arbiter.
package dmem_arbiter_pkg;

   localparam int unsigned ADDR_LEN       = 32;
   localparam int unsigned DATA_LEN       = 32;
   localparam int unsigned MEM_WORDS_LOG2 = 6;

   localparam logic PORT_LSU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   typedef enum logic {
      RSP_IDLE  = 1'b0,
      RSP_VALID = 1'b1
   } rsp_state_t;

endpackage

// File: rtl/dmem_arb_rsp.sv
// Per-port response slot: holds rvalid/rdata (and rerr with DMEM_ARB_BOUNDS_CHECK_EN)
// from the grant edge until the requester accepts it.
module dmem_arb_rsp #(
   parameter int unsigned DATA_LEN = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                gnt,
   input  logic [DATA_LEN-1:0] data,
   input  logic                rready,
   output logic                rvalid,
   output logic [DATA_LEN-1:0] rdata
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
   ,
   input  logic                err,
   output logic                rerr
`endif
);
   import dmem_arbiter_pkg::*;

   rsp_state_t state_q, state_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= RSP_IDLE;
      else          state_q <= state_d;
   end

   // A new grant refills the slot even when the old response is consumed in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RSP_IDLE:  if (gnt) state_d = RSP_VALID;
         RSP_VALID: begin
            if (gnt)         state_d = RSP_VALID;
            else if (rready) state_d = RSP_IDLE;
         end
         default:   state_d = RSP_IDLE;
      endcase
   end

   assign rvalid = (state_q == RSP_VALID);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  rdata <= '0;
      else if (gnt)  rdata <= data;
   end

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  rerr <= 1'b0;
      else if (gnt)  rerr <= err;
   end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Optional bounds check on high address bits: DMEM_ARB_BOUNDS_CHECK_EN.
module dmem_arbiter #(
   parameter int unsigned ADDR_LEN       = 32,
   parameter int unsigned DATA_LEN       = 32,
   parameter int unsigned MEM_WORDS_LOG2 = 6
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                p0_req,
   input  logic                p0_we,
   input  logic [ADDR_LEN-1:0] p0_addr,
   input  logic [DATA_LEN-1:0] p0_wdata,
   output logic                p0_gnt,
   output logic                p0_rvalid,
   output logic [DATA_LEN-1:0] p0_rdata,
   input  logic                p0_rready,
   input  logic                p1_req,
   input  logic                p1_we,
   input  logic [ADDR_LEN-1:0] p1_addr,
   input  logic [DATA_LEN-1:0] p1_wdata,
   output logic                p1_gnt,
   output logic                p1_rvalid,
   output logic [DATA_LEN-1:0] p1_rdata,
   input  logic                p1_rready,
   output logic [ADDR_LEN-1:0] dmem_addr,
   output logic [DATA_LEN-1:0] dmem_wdata,
   output logic                dmem_we,
   input  logic [DATA_LEN-1:0] dmem_rdata
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
   ,
   output logic                p0_rerr,
   output logic                p1_rerr
`endif
);
   import dmem_arbiter_pkg::*;

   logic                elig0, elig1;
   logic                last_q;
   logic                sel_we, sel_oob, oob_en;
   logic [ADDR_LEN-1:0] sel_addr;
   logic [DATA_LEN-1:0] sel_wdata, rsp_data;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
   assign oob_en = 1'b1;
`else
   assign oob_en = 1'b0;
`endif

   // reset_n in the eligibility term keeps grants and dmem_we off during an async reset.
   assign elig0 = reset_n & p0_req & (~p0_rvalid | p0_rready);
   assign elig1 = reset_n & p1_req & (~p1_rvalid | p1_rready);

   always_comb begin
      p0_gnt = elig0 & (~elig1 | (last_q == PORT_DBG));
      p1_gnt = elig1 & ~p0_gnt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    last_q <= PORT_DBG;
      else if (p0_gnt) last_q <= PORT_LSU;
      else if (p1_gnt) last_q <= PORT_DBG;
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (p0_gnt) begin
         sel_we    = p0_we;
         sel_addr  = p0_addr;
         sel_wdata = p0_wdata;
      end else if (p1_gnt) begin
         sel_we    = p1_we;
         sel_addr  = p1_addr;
         sel_wdata = p1_wdata;
      end
   end

   assign sel_oob    = oob_en & (|sel_addr[ADDR_LEN-1:MEM_WORDS_LOG2]);
   assign dmem_addr  = sel_addr;
   assign dmem_wdata = sel_wdata;
   assign dmem_we    = sel_we & ~sel_oob;
   assign rsp_data   = (sel_we | sel_oob) ? '0 : dmem_rdata;

   dmem_arb_rsp #(.DATA_LEN(DATA_LEN)) u_rsp0 (
      .clk     (clk),
      .reset_n (reset_n),
      .gnt     (p0_gnt),
      .data    (rsp_data),
      .rready  (p0_rready),
      .rvalid  (p0_rvalid),
      .rdata   (p0_rdata)
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
      ,
      .err     (sel_oob),
      .rerr    (p0_rerr)
`endif
   );

   dmem_arb_rsp #(.DATA_LEN(DATA_LEN)) u_rsp1 (
      .clk     (clk),
      .reset_n (reset_n),
      .gnt     (p1_gnt),
      .data    (rsp_data),
      .rready  (p1_rready),
      .rvalid  (p1_rvalid),
      .rdata   (p1_rdata)
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
      ,
      .err     (sel_oob),
      .rerr    (p1_rerr)
`endif
   );

endmodule
